l1i_fetch_ctrl: RTL and testbench
=================================

Name: l1i_fetch_ctrl

Overview:
- Fetch sequencer sitting between the PC/redirect logic and the 64-bit L1 instruction RAM.
- Generates one line read per cycle at consecutive 8-byte-aligned addresses.
- Applies credit-based flow control so the fetch queue never overflows, and redirects on jump.
- Buffers returned lines in a DEPTH-entry FIFO that the RV32IMC aligner/decoder drains through a valid/ready handshake.

Parameters:
- DEPTH, 4, fetch-queue entries; power of two, at least 2.
- AW, 32, byte-address width.
- DW, 64, line width (fixed 8 bytes per line).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- jump_flag_i  in  1  redirect request from execute.
- jump_addr_i  in  AW  redirect target, byte address (2-byte aligned).
- hold_flag_i  in  1  pipeline stall; suppresses new issue.
- l1i_re_o  out  1  read enable to the L1I RAM.
- l1i_raddr_o  out  AW  read byte address to the L1I RAM.
- l1i_jump_o  out  1  kill to the L1I RAM; equals jump_flag_i.
- l1i_re_i  in  1  L1I response valid, one cycle after issue.
- l1i_rdata_i  in  DW  L1I response line.
- l1i_raddr_i  in  AW  L1I echoed request address.
- fq_valid_o  out  1  queue head valid.
- fq_data_o  out  DW  queue head line.
- fq_addr_o  out  AW  queue head byte address; low 3 bits give the start offset after a jump.
- fq_ready_i  in  1  consumer accepts the head.
- fq_count_o  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - fpc <= RESET_PC; count, rd_ptr, wr_ptr, inflight <= 0.
  - l1i_re_o=0, l1i_raddr_o=0, fq_valid_o=0, fq_data_o=0, fq_addr_o=0, fq_count_o=0.
  - Reset asserted mid-operation discards the queue and any in-flight read.
- Issue (combinational): l1i_re_o = rst & !jump_flag_i & !hold_flag_i & (count + inflight < DEPTH).
  - When l1i_re_o=1, l1i_raddr_o = fpc; otherwise l1i_raddr_o = 0.
  - On issue, fpc <= {fpc[AW-1:3],3'b000} + 8, wrapping modulo 2^AW. inflight <= 1.
  - With no issue, inflight <= 0. At most one read is outstanding because L1I latency is exactly 1.
- Response: when l1i_re_i=1 and inflight=1 and jump_flag_i=0, push {l1i_rdata_i, l1i_raddr_i} at wr_ptr.
  - A response arriving with inflight=0 is dropped (stale).
  - Credits guarantee that a push never meets a full queue.
- Pop: when fq_valid_o & fq_ready_i, rd_ptr advances.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- fq_valid_o = (count != 0) & !jump_flag_i. fq_data_o and fq_addr_o show the head entry, or 0 when the queue is empty.
- Jump (jump_flag_i=1, one cycle):
  - count, rd_ptr, wr_ptr <= 0; inflight <= 0.
  - Any response present that cycle is dropped; no issue that cycle; fpc <= jump_addr_i.
  - l1i_jump_o=1, so the L1I drops the read issued in the previous cycle.
  - First issue occurs the next cycle at the full unaligned jump_addr_i. The L1I indexes raddr>>3, so the whole line returns, and fq_addr_o carries the offset.
- Jump and hold together: jump takes effect; issue stays suppressed while hold persists.
- Hold: blocks new issue only. An outstanding read still completes into its reserved credit. The queue still drains.
- Pop attempted during a jump cycle is ignored.
- Back-to-back jumps: each one reloads fpc, and the last one wins.

Test Plan:
- Reset release with RESET_PC=0, fq_ready_i=1, L1I model 1-cycle → reads at 0x0, 0x8, 0x10 …; first fq_valid_o in the 2nd cycle after reset release; fq_addr_o sequence 0x0, 0x8, 0x10 with matching line data.
- fq_ready_i=0, DEPTH=4 → exactly 4 issues, then l1i_re_o=0 and fq_count_o=4 with no overwrite. A single pop → one new issue and count returns to 4.
- Jump to 0x106 while 2 lines are queued and 1 read is in flight → count=0 next cycle; next issue raddr=0x106, then 0x108; first popped entry has fq_addr_o=0x106 and line data of address 0x100.
- hold_flag_i high for 3 cycles just after an issue → the in-flight line is still queued; no issue for 3 cycles; resume at fpc+8 with no skipped or duplicated address.
- Jump and hold asserted in the same cycle, hold held 2 more cycles → no issue until hold drops; first issue is at jump_addr_i.
- Reset asserted while queue is full and a read is in flight → all outputs 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/l1i_fetch_ctrl.sv
// Fetch sequencer for the 64-bit L1 instruction RAM: issues one line read per cycle,
// reserves a queue credit per outstanding read, and buffers returned lines for the aligner.
module l1i_fetch_ctrl #(
    parameter int               DEPTH    = 4,
    parameter int               AW       = 32,
    parameter int               DW       = 64,
    parameter logic [AW-1:0]    RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        jump_flag_i,
    input  logic [AW-1:0]               jump_addr_i,
    input  logic                        hold_flag_i,
    output logic                        l1i_re_o,
    output logic [AW-1:0]               l1i_raddr_o,
    output logic                        l1i_jump_o,
    input  logic                        l1i_re_i,
    input  logic [DW-1:0]               l1i_rdata_i,
    input  logic [AW-1:0]               l1i_raddr_i,
    output logic                        fq_valid_o,
    output logic [DW-1:0]               fq_data_o,
    output logic [AW-1:0]               fq_addr_o,
    input  logic                        fq_ready_i,
    output logic [$clog2(DEPTH):0]      fq_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fpc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          inflight;

    logic [DW-1:0] data_mem [DEPTH];
    logic [AW-1:0] addr_mem [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic [CW:0]   credits_used;

    // An in-flight read already owns a queue slot, so it counts against the credit limit.
    assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue        = rst & ~jump_flag_i & ~hold_flag_i & (credits_used < (CW+1)'(DEPTH));

    assign l1i_re_o    = issue;
    assign l1i_raddr_o = issue ? fpc : '0;
    assign l1i_jump_o  = jump_flag_i;

    assign not_empty  = (count != '0);
    assign push       = l1i_re_i & inflight & ~jump_flag_i;
    assign fq_valid_o = not_empty & ~jump_flag_i;
    assign pop        = fq_valid_o & fq_ready_i;

    assign fq_data_o  = not_empty ? data_mem[rd_ptr] : '0;
    assign fq_addr_o  = not_empty ? addr_mem[rd_ptr] : '0;
    assign fq_count_o = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc      <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else if (jump_flag_i) begin
            // Redirect flushes the queue and forgets the read the L1I is told to kill.
            fpc      <= jump_addr_i;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc <= {fpc[AW-1:3], 3'b000} + AW'(8);
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= l1i_rdata_i;
            addr_mem[wr_ptr] <= l1i_raddr_i;
        end
    end

endmodule

// File: tb/tb_l1i_fetch_ctrl.sv
// Directed bench for l1i_fetch_ctrl with a 1-cycle L1I RAM model returning address-derived lines.
module tb_l1i_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_flag_i = 1'b0;
    logic        l1i_re_o;
    logic [31:0] l1i_raddr_o;
    logic        l1i_jump_o;
    logic        l1i_re_i = 1'b0;
    logic [63:0] l1i_rdata_i = '0;
    logic [31:0] l1i_raddr_i = '0;
    logic        fq_valid_o;
    logic [63:0] fq_data_o;
    logic [31:0] fq_addr_o;
    logic        fq_ready_i = 1'b1;
    logic [2:0]  fq_count_o;

    int tests = 0;
    int fails = 0;

    l1i_fetch_ctrl #(.DEPTH(4), .AW(32), .DW(64), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
        .l1i_re_o(l1i_re_o), .l1i_raddr_o(l1i_raddr_o), .l1i_jump_o(l1i_jump_o),
        .l1i_re_i(l1i_re_i), .l1i_rdata_i(l1i_rdata_i), .l1i_raddr_i(l1i_raddr_i),
        .fq_valid_o(fq_valid_o), .fq_data_o(fq_data_o), .fq_addr_o(fq_addr_o),
        .fq_ready_i(fq_ready_i), .fq_count_o(fq_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [31:0] idx;
        idx = a >> 3;
        return {32'hC0DE0000 ^ idx, ~idx};
    endfunction

    // L1I RAM model: line indexed by raddr>>3, echoed address, exactly one cycle of latency.
    always @(posedge clk) begin
        l1i_re_i    <= l1i_re_o;
        l1i_raddr_i <= l1i_raddr_o;
        l1i_rdata_i <= line_of(l1i_raddr_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fq_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if ({l1i_re_o, l1i_raddr_o, fq_valid_o, fq_data_o, fq_addr_o, fq_count_o} !== '0) begin
            $display("FAIL reset_outputs: re=%b raddr=%h valid=%b data=%h addr=%h count=%0d, required all zero",
                     l1i_re_o, l1i_raddr_o, fq_valid_o, fq_data_o, fq_addr_o, fq_count_o);
            fails++;
        end
    endtask

    task automatic test_fetch();
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if ({l1i_re_o, l1i_raddr_o, fq_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL fetch_c0: re=%b raddr=%h valid=%b, required 1 00000000 0", l1i_re_o, l1i_raddr_o, fq_valid_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({l1i_re_o, l1i_raddr_o, fq_valid_o, fq_count_o} !== {1'b1, 32'h8, 1'b0, 3'd0}) begin
            $display("FAIL fetch_c1: re=%b raddr=%h valid=%b count=%0d, required 1 00000008 0 0",
                     l1i_re_o, l1i_raddr_o, fq_valid_o, fq_count_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({fq_valid_o, fq_addr_o, fq_data_o, l1i_raddr_o, fq_count_o} !==
            {1'b1, 32'h0, line_of(32'h0), 32'h10, 3'd1}) begin
            $display("FAIL fetch_c2: valid=%b addr=%h data=%h raddr=%h count=%0d, required 1 0 %h 10 1",
                     fq_valid_o, fq_addr_o, fq_data_o, l1i_raddr_o, fq_count_o, line_of(32'h0));
            fails++;
        end
        tick(); #1;
        tests++;
        if ({fq_valid_o, fq_addr_o, fq_data_o, l1i_raddr_o, fq_count_o} !==
            {1'b1, 32'h8, line_of(32'h8), 32'h18, 3'd1}) begin
            $display("FAIL fetch_c3: valid=%b addr=%h data=%h raddr=%h count=%0d, required 1 8 %h 18 1",
                     fq_valid_o, fq_addr_o, fq_data_o, l1i_raddr_o, fq_count_o, line_of(32'h8));
            fails++;
        end
        tick(); #1;
        tests++;
        if ({fq_addr_o, fq_data_o} !== {32'h10, line_of(32'h10)}) begin
            $display("FAIL fetch_c4: addr=%h data=%h, required 10 %h", fq_addr_o, fq_data_o, line_of(32'h10));
            fails++;
        end
    endtask

    task automatic test_full();
        int n;
        fq_ready_i = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (l1i_re_o) n++;
            tick();
        end
        #1;
        tests++;
        if (n !== 4) begin
            $display("FAIL full_issue_count: issues=%0d, required 4", n);
            fails++;
        end
        tests++;
        if ({l1i_re_o, fq_count_o, fq_valid_o, fq_addr_o, fq_data_o} !== {1'b0, 3'd4, 1'b1, 32'h0, line_of(32'h0)}) begin
            $display("FAIL full_state: re=%b count=%0d valid=%b addr=%h data=%h, required 0 4 1 0 %h",
                     l1i_re_o, fq_count_o, fq_valid_o, fq_addr_o, fq_data_o, line_of(32'h0));
            fails++;
        end
        fq_ready_i = 1'b1;
        tick();
        fq_ready_i = 1'b0;
        #1;
        tests++;
        if ({fq_count_o, l1i_re_o, l1i_raddr_o} !== {3'd3, 1'b1, 32'h20}) begin
            $display("FAIL full_pop_issue: count=%0d re=%b raddr=%h, required 3 1 20", fq_count_o, l1i_re_o, l1i_raddr_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({fq_count_o, l1i_re_o} !== {3'd3, 1'b0}) begin
            $display("FAIL full_refill: count=%0d re=%b, required 3 0", fq_count_o, l1i_re_o);
            fails++;
        end
        tick(); tick(); #1;
        tests++;
        if ({fq_count_o, l1i_re_o, fq_addr_o, fq_data_o} !== {3'd4, 1'b0, 32'h8, line_of(32'h8)}) begin
            $display("FAIL full_again: count=%0d re=%b addr=%h data=%h, required 4 0 8 %h",
                     fq_count_o, l1i_re_o, fq_addr_o, fq_data_o, line_of(32'h8));
            fails++;
        end
    endtask

    task automatic test_jump();
        fq_ready_i = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick(); tick(); #1;
        tests++;
        if ({fq_count_o, l1i_re_o, l1i_raddr_o} !== {3'd2, 1'b1, 32'h18}) begin
            $display("FAIL jump_setup: count=%0d re=%b raddr=%h, required 2 1 18", fq_count_o, l1i_re_o, l1i_raddr_o);
            fails++;
        end
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h106;
        #1;
        tests++;
        if ({l1i_re_o, l1i_jump_o, fq_valid_o} !== 3'b010) begin
            $display("FAIL jump_cycle: re=%b jump=%b valid=%b, required 0 1 0", l1i_re_o, l1i_jump_o, fq_valid_o);
            fails++;
        end
        tick();
        jump_flag_i = 1'b0;
        fq_ready_i = 1'b1;
        #1;
        tests++;
        if ({fq_count_o, l1i_re_o, l1i_raddr_o, fq_valid_o} !== {3'd0, 1'b1, 32'h106, 1'b0}) begin
            $display("FAIL jump_target: count=%0d re=%b raddr=%h valid=%b, required 0 1 106 0",
                     fq_count_o, l1i_re_o, l1i_raddr_o, fq_valid_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({l1i_raddr_o, fq_valid_o} !== {32'h108, 1'b0}) begin
            $display("FAIL jump_next: raddr=%h valid=%b, required 108 0", l1i_raddr_o, fq_valid_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({fq_valid_o, fq_addr_o, fq_data_o, l1i_raddr_o} !== {1'b1, 32'h106, line_of(32'h100), 32'h110}) begin
            $display("FAIL jump_head: valid=%b addr=%h data=%h raddr=%h, required 1 106 %h 110",
                     fq_valid_o, fq_addr_o, fq_data_o, l1i_raddr_o, line_of(32'h100));
            fails++;
        end
    endtask

    task automatic test_hold();
        tick();
        hold_flag_i = 1'b1;
        fq_ready_i = 1'b0;
        #1;
        tests++;
        if ({l1i_re_o, fq_count_o, fq_addr_o} !== {1'b0, 3'd1, 32'h108}) begin
            $display("FAIL hold_c0: re=%b count=%0d addr=%h, required 0 1 108", l1i_re_o, fq_count_o, fq_addr_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({l1i_re_o, fq_count_o} !== {1'b0, 3'd2}) begin
            $display("FAIL hold_inflight_kept: re=%b count=%0d, required 0 2", l1i_re_o, fq_count_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({l1i_re_o, fq_count_o} !== {1'b0, 3'd2}) begin
            $display("FAIL hold_c2: re=%b count=%0d, required 0 2", l1i_re_o, fq_count_o);
            fails++;
        end
        tick();
        hold_flag_i = 1'b0;
        #1;
        tests++;
        if ({l1i_re_o, l1i_raddr_o, fq_count_o} !== {1'b1, 32'h118, 3'd2}) begin
            $display("FAIL hold_resume: re=%b raddr=%h count=%0d, required 1 118 2", l1i_re_o, l1i_raddr_o, fq_count_o);
            fails++;
        end
    endtask

    task automatic test_jump_hold();
        tick();
        jump_flag_i = 1'b1;
        hold_flag_i = 1'b1;
        jump_addr_i = 32'h204;
        #1;
        tests++;
        if ({l1i_re_o, l1i_jump_o, fq_valid_o} !== 3'b010) begin
            $display("FAIL jh_cycle: re=%b jump=%b valid=%b, required 0 1 0", l1i_re_o, l1i_jump_o, fq_valid_o);
            fails++;
        end
        tick();
        jump_flag_i = 1'b0;
        #1;
        tests++;
        if ({l1i_re_o, fq_count_o} !== {1'b0, 3'd0}) begin
            $display("FAIL jh_hold1: re=%b count=%0d, required 0 0", l1i_re_o, fq_count_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({l1i_re_o, fq_count_o} !== {1'b0, 3'd0}) begin
            $display("FAIL jh_hold2: re=%b count=%0d, required 0 0", l1i_re_o, fq_count_o);
            fails++;
        end
        tick();
        hold_flag_i = 1'b0;
        #1;
        tests++;
        if ({l1i_re_o, l1i_raddr_o} !== {1'b1, 32'h204}) begin
            $display("FAIL jh_first_issue: re=%b raddr=%h, required 1 204", l1i_re_o, l1i_raddr_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({l1i_re_o, l1i_raddr_o} !== {1'b1, 32'h208}) begin
            $display("FAIL jh_second_issue: re=%b raddr=%h, required 1 208", l1i_re_o, l1i_raddr_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({fq_count_o, fq_addr_o, fq_data_o} !== {3'd1, 32'h204, line_of(32'h200)}) begin
            $display("FAIL jh_head: count=%0d addr=%h data=%h, required 1 204 %h",
                     fq_count_o, fq_addr_o, fq_data_o, line_of(32'h200));
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h300;
        fq_ready_i = 1'b1;
        #1;
        tests++;
        if ({l1i_re_o, fq_valid_o} !== 2'b00) begin
            $display("FAIL b2b_first: re=%b valid=%b, required 0 0 (pop during jump)", l1i_re_o, fq_valid_o);
            fails++;
        end
        tick();
        jump_addr_i = 32'h40A;
        #1;
        tests++;
        if ({l1i_re_o, fq_count_o} !== {1'b0, 3'd0}) begin
            $display("FAIL b2b_second: re=%b count=%0d, required 0 0", l1i_re_o, fq_count_o);
            fails++;
        end
        tick();
        jump_flag_i = 1'b0;
        #1;
        tests++;
        if ({l1i_re_o, l1i_raddr_o} !== {1'b1, 32'h40A}) begin
            $display("FAIL b2b_last_wins: re=%b raddr=%h, required 1 40a", l1i_re_o, l1i_raddr_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if (l1i_raddr_o !== 32'h410) begin
            $display("FAIL b2b_next: raddr=%h, required 410", l1i_raddr_o);
            fails++;
        end
        tick(); #1;
        tests++;
        if ({fq_valid_o, fq_addr_o, fq_data_o} !== {1'b1, 32'h40A, line_of(32'h408)}) begin
            $display("FAIL b2b_head: valid=%b addr=%h data=%h, required 1 40a %h",
                     fq_valid_o, fq_addr_o, fq_data_o, line_of(32'h408));
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        fq_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            if (fq_count_o == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        tests++;
        if (!found) begin
            $display("FAIL rmid_fill: count=%0d, required 3 within 10 cycles", fq_count_o);
            fails++;
        end
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if ({l1i_re_o, l1i_raddr_o, fq_valid_o, fq_data_o, fq_addr_o, fq_count_o} !== '0) begin
            $display("FAIL rmid_async: re=%b raddr=%h valid=%b data=%h addr=%h count=%0d, required all zero",
                     l1i_re_o, l1i_raddr_o, fq_valid_o, fq_data_o, fq_addr_o, fq_count_o);
            fails++;
        end
        tick();
        rst = 1'b1;
        fq_ready_i = 1'b1;
        #1;
        tests++;
        if ({l1i_re_o, l1i_raddr_o, fq_count_o} !== {1'b1, 32'h0, 3'd0}) begin
            $display("FAIL rmid_restart: re=%b raddr=%h count=%0d, required 1 0 0", l1i_re_o, l1i_raddr_o, fq_count_o);
            fails++;
        end
        tick(); tick(); #1;
        tests++;
        if ({fq_valid_o, fq_addr_o, fq_data_o} !== {1'b1, 32'h0, line_of(32'h0)}) begin
            $display("FAIL rmid_head: valid=%b addr=%h data=%h, required 1 0 %h",
                     fq_valid_o, fq_addr_o, fq_data_o, line_of(32'h0));
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_full();
        test_jump();
        test_hold();
        test_jump_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
